// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the 2-read / 1-write register file.
//   WIDTH_DEF / DEPTH_DEF / AW_DEF : default geometry (8 x 8-bit, 3-bit address)
//   ZERO_REG                       : address of the hardwired-zero register
//   ZERO_WORD                      : all-zero data word
package reg_file_2r1w_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = 3;

  localparam int unsigned ZERO_REG = 0;

  localparam logic [WIDTH_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/reg_file_2r1w_word.sv
// One WIDTH-bit register with load enable and synchronous active-low reset.
//   CLK : rising-edge clock
//   R_  : synchronous reset, active-low (wins over EN)
//   EN  : load enable; Q holds when low
//   D   : data in
//   Q   : registered data out
module reg_word #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             R_,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;

  always_comb begin
    word_d = word_q;
    if (!R_) begin
      word_d = '0;
    end else if (EN) begin
      word_d = D;
    end
  end

  always_ff @(posedge CLK) begin
    word_q <= word_d;
  end

  assign Q = word_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// General-purpose register file: one synchronous write port, two registered
// read ports with write-to-read bypass. Register 0 reads as zero.
//   CLK           : rising-edge clock
//   R_            : synchronous reset, active-low; clears storage and RD1/RD2
//   WE/WA/WD      : write enable, address, data (WA = 0 ignored)
//   RE1/RA1 -> RD1: read port 1, 1-cycle latency, holds when RE1 low
//   RE2/RA2 -> RD2: read port 2, independent of port 1
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             CLK,
  input  logic             R_,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic             RE1,
  input  logic [AW-1:0]    RA1,
  output logic [WIDTH-1:0] RD1,
  input  logic             RE2,
  input  logic [AW-1:0]    RA2,
  output logic [WIDTH-1:0] RD2
);

  // Storage view; entry 0 is the constant zero word, not a register.
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Write decode only covers addresses 1..DEPTH-1, which masks register 0.
  logic [DEPTH-1:1] we_sel;

  logic             wa_nonzero;
  logic             byp1;
  logic             byp2;
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;

  always_comb begin
    we_sel = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      we_sel[i] = WE && (WA == AW'(i));
    end
  end

  assign mem[0] = WIDTH'(ZERO_WORD);

  for (genvar g = 1; g < DEPTH; g++) begin : g_store
    reg_word #(.WIDTH(WIDTH)) u_word (
      .CLK (CLK),
      .R_  (R_),
      .EN  (we_sel[g]),
      .D   (WD),
      .Q   (mem[g])
    );
  end

  // A same-edge write to the addressed register forwards WD; RA = 0 never
  // bypasses, so mem[0] keeps register 0 reading as zero.
  always_comb begin
    wa_nonzero = (WA != AW'(ZERO_REG));
    byp1       = WE && wa_nonzero && (WA == RA1);
    byp2       = WE && wa_nonzero && (WA == RA2);
    rd1_d      = byp1 ? WD : mem[RA1];
    rd2_d      = byp2 ? WD : mem[RA2];
  end

  reg_word #(.WIDTH(WIDTH)) u_rd1 (
    .CLK (CLK),
    .R_  (R_),
    .EN  (RE1),
    .D   (rd1_d),
    .Q   (RD1)
  );

  reg_word #(.WIDTH(WIDTH)) u_rd2 (
    .CLK (CLK),
    .R_  (R_),
    .EN  (RE2),
    .D   (rd2_d),
    .Q   (RD2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  logic       clk = 1'b0;
  logic       r_n;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       re1;
  logic [2:0] ra1;
  logic [7:0] rd1;
  logic       re2;
  logic [2:0] ra2;
  logic [7:0] rd2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register contents plus expected read outputs.
  logic [7:0] model [8];
  logic [7:0] m_rd1;
  logic [7:0] m_rd2;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
    .CLK (clk),
    .R_  (r_n),
    .WE  (we),
    .WA  (wa),
    .WD  (wd),
    .RE1 (re1),
    .RA1 (ra1),
    .RD1 (rd1),
    .RE2 (re2),
    .RA2 (ra2),
    .RD2 (rd2)
  );

  function automatic logic [7:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (we && r_n && wa == a) return wd;
    return model[a];
  endfunction

  // Apply current inputs to the model, advance one edge, sample 1 ns later.
  task automatic tick();
    logic [7:0] n1;
    logic [7:0] n2;
    n1 = m_rd1;
    n2 = m_rd2;
    if (!r_n) begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      n1 = 8'h00;
      n2 = 8'h00;
    end else begin
      if (re1) n1 = model_read(ra1);
      if (re2) n2 = model_read(ra2);
      if (we && wa != 3'd0) model[wa] = wd;
    end
    @(posedge clk);
    #1;
    m_rd1 = n1;
    m_rd2 = n2;
  endtask

  task automatic idle();
    r_n = 1'b1; we = 1'b0; wa = '0; wd = '0;
    re1 = 1'b0; ra1 = '0; re2 = 1'b0; ra2 = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    idle();
    we = 1'b1; wa = a; wd = d;
    tick();
  endtask

  task automatic test_reset();
    idle();
    r_n = 1'b0; we = 1'b1; wa = 3'd3; wd = 8'hAA; re1 = 1'b1; ra1 = 3'd3;
    tick();
    tick();
    n_cmp++;
    if (rd1 !== 8'h00) begin n_bad++; $display("FAIL reset_rd1 got %h want 00", rd1); end
    n_cmp++;
    if (rd2 !== 8'h00) begin n_bad++; $display("FAIL reset_rd2 got %h want 00", rd2); end
    idle();
    re1 = 1'b1; ra1 = 3'd3;
    tick();
    n_cmp++;
    if (rd1 !== 8'h00) begin n_bad++; $display("FAIL reset_reg3 got %h want 00", rd1); end
  endtask

  task automatic test_write_read();
    wr(3'd5, 8'h5C);
    idle();
    re1 = 1'b1; ra1 = 3'd5;
    tick();
    n_cmp++;
    if (rd1 !== 8'h5C) begin n_bad++; $display("FAIL wr_rd got %h want 5c", rd1); end
    wr(3'd5, 8'h11);
    n_cmp++;
    if (rd1 !== 8'h5C) begin n_bad++; $display("FAIL rd_hold got %h want 5c", rd1); end
    idle();
    re2 = 1'b1; ra2 = 3'd5;
    tick();
    n_cmp++;
    if (rd2 !== 8'h11) begin n_bad++; $display("FAIL rewrite_rd2 got %h want 11", rd2); end
  endtask

  task automatic test_zero_reg();
    wr(3'd0, 8'hFF);
    idle();
    re1 = 1'b1; re2 = 1'b1; ra1 = 3'd0; ra2 = 3'd0;
    tick();
    n_cmp++;
    if (rd1 !== 8'h00) begin n_bad++; $display("FAIL zero_rd1 got %h want 00", rd1); end
    n_cmp++;
    if (rd2 !== 8'h00) begin n_bad++; $display("FAIL zero_rd2 got %h want 00", rd2); end
    // Preload a nonzero value so a wrong R0 read would be visible.
    wr(3'd1, 8'h99);
    idle();
    re1 = 1'b1; ra1 = 3'd1;
    tick();
    idle();
    we = 1'b1; wa = 3'd0; wd = 8'hFF; re1 = 1'b1; ra1 = 3'd0;
    tick();
    n_cmp++;
    if (rd1 !== 8'h00) begin n_bad++; $display("FAIL zero_same_cycle got %h want 00", rd1); end
  endtask

  task automatic test_bypass();
    wr(3'd2, 8'h33);
    wr(3'd4, 8'h07);
    idle();
    we = 1'b1; wa = 3'd2; wd = 8'h44;
    re1 = 1'b1; re2 = 1'b1; ra1 = 3'd2; ra2 = 3'd2;
    tick();
    n_cmp++;
    if (rd1 !== 8'h44) begin n_bad++; $display("FAIL byp_both_rd1 got %h want 44", rd1); end
    n_cmp++;
    if (rd2 !== 8'h44) begin n_bad++; $display("FAIL byp_both_rd2 got %h want 44", rd2); end
    wr(3'd2, 8'h33);
    idle();
    we = 1'b1; wa = 3'd2; wd = 8'h44;
    re1 = 1'b1; re2 = 1'b1; ra1 = 3'd2; ra2 = 3'd4;
    tick();
    n_cmp++;
    if (rd1 !== 8'h44) begin n_bad++; $display("FAIL byp_one_rd1 got %h want 44", rd1); end
    n_cmp++;
    if (rd2 !== 8'h07) begin n_bad++; $display("FAIL byp_one_rd2 got %h want 07", rd2); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want;
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(i * 16));
    idle();
    re1 = 1'b1; ra1 = 3'd7;
    tick();
    n_cmp++;
    if (rd1 !== 8'h70) begin n_bad++; $display("FAIL fill_reg7 got %h want 70", rd1); end
    idle();
    r_n = 1'b0; we = 1'b1; wa = 3'd6; wd = 8'hEE;
    tick();
    for (int i = 0; i < 8; i++) begin
      idle();
      re1 = 1'b1; ra1 = 3'(i);
      re2 = 1'b1; ra2 = 3'(7 - i);
      tick();
      want = 8'h00;
      n_cmp++;
      if (rd1 !== want) begin n_bad++; $display("FAIL rst_mid_rd1 reg%0d got %h want %h", i, rd1, want); end
      n_cmp++;
      if (rd2 !== want) begin n_bad++; $display("FAIL rst_mid_rd2 reg%0d got %h want %h", 7 - i, rd2, want); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      r_n = ($urandom_range(63) != 0);
      we  = $urandom_range(1);
      wa  = 3'($urandom_range(7));
      wd  = 8'($urandom);
      re1 = ($urandom_range(3) != 0);
      re2 = ($urandom_range(3) != 0);
      // Bias read addresses toward the write address to exercise bypass.
      ra1 = ($urandom_range(3) == 0) ? wa : 3'($urandom_range(7));
      ra2 = ($urandom_range(3) == 0) ? wa : 3'($urandom_range(7));
      tick();
      n_cmp++;
      if (rd1 !== m_rd1) begin n_bad++; $display("FAIL rand_rd1 cyc %0d got %h want %h", c, rd1, m_rd1); end
      n_cmp++;
      if (rd2 !== m_rd2) begin n_bad++; $display("FAIL rand_rd2 cyc %0d got %h want %h", c, rd2, m_rd2); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    m_rd1 = 8'h00;
    m_rd2 = 8'h00;
    idle();
    #1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
